snn_infer_ctrl: RTL and testbench
=================================

# snn_infer_ctrl

Wishbone-slave inference scheduler for the SNN accelerator in the servant SoC. Firmware configures group size, inference count and watchdog, then issues START. The block pulses the accelerator start, counts output-buffer writes and captures the `{p2,p1}` prediction on the first write of every group of N_OUT writes into a result FIFO. It raises an interrupt so the SERV core no longer polls accelerator internals.

## Interface
- FIFO_DEPTH, 4: result FIFO entries, power of two, ≥2
- CNT_W, 16: width of N_OUT, N_INFER and DONE_CNT counters
- TO_W, 24: timeout counter width
- wb_clk  in  1  system clock
- wb_rst_n  in  1  reset, asynchronous, active-low
- wb_adr_i  in  3  word address (byte offset/4)
- wb_dat_i  in  32  write data
- wb_we_i  in  1  write enable
- wb_cyc_i, wb_stb_i  in  1 each  bus cycle / strobe
- wb_dat_o  out  32  read data, registered
- wb_ack_o  out  1  single-cycle acknowledge
- snn_start_o  out  1  one-cycle accelerator start pulse
- snn_wr_en_i  in  1  accelerator output-buffer write strobe
- snn_p1_i, snn_p2_i  in  16 each  signed class scores
- irq_o  out  1  registered interrupt

## Operation
- Registers (word address):
  - 0 CTRL: [0] START (W1 pulse), [1] IRQ_EN (RW), [2] ABORT (W1 pulse).
  - 1 STATUS: [1:0] state, [7:4] fifo_count, [8] OVF sticky, [9] TO sticky. W1C on [9:8].
  - 2 N_OUT, reset 1. 0 is treated as 1.
  - 3 N_INFER, reset 0 = continuous.
  - 4 TIMEOUT, reset 0 = disabled.
  - 5 RESULT: a read pops `{p2,p1}`. Reading an empty FIFO returns 0 and does not pop.
  - 6 DONE_CNT (RO): inferences completed since last START.
- FSM IDLE(0) → START(1) → RUN(2):
  - IDLE: START write → START state. DONE_CNT, grp_cnt and to_cnt clear. N_OUT, N_INFER and TIMEOUT are shadowed.
  - START: snn_start_o=1 for exactly one cycle, then RUN.
  - RUN, on snn_wr_en_i:
    - If grp_cnt==0, push `{p2,p1}`.
    - grp_cnt++. When grp_cnt==N_OUT-1, wrap to 0 and increment DONE_CNT.
    - If N_INFER≠0 and the new DONE_CNT==N_INFER, go to IDLE.
  - RUN, to_cnt:
    - Clears on every wr_en, otherwise increments.
    - When to_cnt reaches TIMEOUT (≠0), set TO and go to IDLE.
  - ABORT in any state → IDLE, grp_cnt=0. FIFO contents are kept.
- snn_wr_en_i is ignored in IDLE and START.
- Boundary cases:
  - Push when FIFO full and no pop in the same cycle: entry dropped, OVF set.
  - Push and pop in the same cycle when full: both succeed, OVF not set.
  - START while not IDLE: ignored.
  - START and ABORT in the same write: ABORT wins, FSM ends in IDLE.
  - DONE_CNT saturates at all-ones.
- irq_o = IRQ_EN & (fifo_count≠0 | TO), registered.

## Timing
- Reset values:
  - Outputs: wb_ack_o=0, wb_dat_o=0, snn_start_o=0, irq_o=0.
  - Internal state: FSM=IDLE, FIFO empty, all sticky bits and counters 0.
- Reset asserted mid-run aborts immediately. There is no pulse on snn_start_o.
- Wishbone:
  - wb_ack_o asserts the cycle after cyc&stb is sampled high with ack low, and is held for one cycle only.
  - Minimum access is two cycles. Read data is valid with ack.
  - The register write and the RESULT pop take effect at the ack edge.
- START written with ack at edge T: state START during T..T+1, snn_start_o high that cycle, RUN from T+2.
- wr_en sampled at edge E: FIFO entry and counters are updated after E. STATUS reads reflect this from E+1. irq_o rises at E+2.
- Timeout fires TIMEOUT cycles after the last wr_en or after RUN entry.

## Structure
- Package snn_ctrl_pkg holds:
  - register word offsets
  - CTRL/STATUS bit positions
  - FSM state encoding (IDLE=0, START=1, RUN=2)
- Sub-module snn_result_fifo: synchronous FIFO with parameters FIFO_DEPTH and width 32, push/pop/full/empty/count outputs, async active-low reset. Simultaneous push and pop when full is legal.

## Test plan
- Reset: all outputs 0. N_OUT reads 1, STATUS reads 0, RESULT reads 0.
- N_OUT=4, N_INFER=2, IRQ_EN=1, START; 8 wr_en with p1=10..17, p2=-1 → FIFO holds {-1,10},{-1,14}; DONE_CNT=2; IDLE after 8th write; irq_o=1 until 2nd RESULT read.
- N_OUT=1, continuous, 5 wr_en with p1=1..5, no reads → fifo_count=4, OVF=1; reads return p1 1,2,3,4, then 0.
- FIFO full plus RESULT read coincident with wr_en (p1=9) → count stays 4, OVF=0, last entry p1=9.
- TIMEOUT=100, START, no wr_en → TO set 100 cycles after RUN entry, FSM IDLE, irq_o=1; W1C on TO clears irq_o.
- N_OUT=3; ABORT after 2 writes, then START again; wr_en with p1=7 → entry p1=7 captured (grp_cnt restarted), DONE_CNT=0.

Source files
------------

// File: rtl/snn_infer_ctrl_pkg.sv
// Shared definitions for the SNN inference scheduler: register map, bit positions, FSM codes.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package snn_ctrl_pkg;

    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_STATUS   = 3'd1;
    localparam logic [2:0] REG_N_OUT    = 3'd2;
    localparam logic [2:0] REG_N_INFER  = 3'd3;
    localparam logic [2:0] REG_TIMEOUT  = 3'd4;
    localparam logic [2:0] REG_RESULT   = 3'd5;
    localparam logic [2:0] REG_DONE_CNT = 3'd6;

    localparam int CTRL_START    = 0;
    localparam int CTRL_IRQ_EN   = 1;
    localparam int CTRL_ABORT    = 2;
    localparam int STAT_FIFO_LSB = 4;
    localparam int STAT_OVF      = 8;
    localparam int STAT_TO       = 9;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    typedef struct packed {
        logic signed [15:0] p2;
        logic signed [15:0] p1;
    } result_t;

endpackage

// File: rtl/snn_infer_ctrl_if.sv
// Wishbone classic slave bus bundle for the inference scheduler.
// Latency: n/a (wiring only).
// Backpressure: slave acks every access one cycle after it is sampled.
interface snn_wb_if;
    logic [2:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;

    modport master (output wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i,
                    input  wb_dat_o, wb_ack_o);
    modport slave  (input  wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i,
                    output wb_dat_o, wb_ack_o);
endinterface

// File: rtl/snn_result_fifo.sv
// Synchronous result FIFO holding captured prediction words.
// Latency: push visible on pop_dat one cycle after the push edge.
// Backpressure: push when full is dropped unless a pop happens in the same cycle.
module snn_result_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int WIDTH      = 32
) (
    input  logic                          wb_clk,
    input  logic                          wb_rst_n,
    input  logic                          push,
    input  logic [WIDTH-1:0]              push_dat,
    input  logic                          pop,
    output logic [WIDTH-1:0]              pop_dat,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge wb_clk) begin
        if (do_push)
            mem[wr_ptr] <= push_dat;
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/snn_infer_ctrl.sv
// Wishbone-controlled scheduler: starts the SNN, captures one prediction per output group, raises irq.
// Latency: ack one cycle after cyc&stb; FIFO/counters update the edge after wr_en is sampled.
// Backpressure: none on the accelerator side; a full FIFO drops the capture and sets OVF.
module snn_infer_ctrl
    import snn_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16,
    parameter int TO_W       = 24
) (
    input  logic        wb_clk,
    input  logic        wb_rst_n,
    snn_wb_if.slave     wb,
    output logic        snn_start_o,
    input  logic        snn_wr_en_i,
    input  logic [15:0] snn_p1_i,
    input  logic [15:0] snn_p2_i,
    output logic        irq_o
);
    localparam int FCW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]       state;
    logic [CNT_W-1:0] n_out, n_infer, n_out_s, n_infer_s, grp_cnt, done_cnt, done_nxt;
    logic [TO_W-1:0]  timeout, timeout_s, to_cnt, to_nxt;
    logic             irq_en, ovf, to_flag;
    logic             acc, wr_acc, rd_acc, start_req, abort_req;
    logic             run_wr, grp_last, push, pop, to_fire;
    logic             fifo_full, fifo_empty;
    logic [31:0]      fifo_dat, rd_mux;
    logic [FCW-1:0]   fifo_cnt;
    logic             unused_dat;

    assign unused_dat = ^wb.wb_dat_i[31:TO_W];

    assign acc       = wb.wb_cyc_i & wb.wb_stb_i & ~wb.wb_ack_o;
    assign wr_acc    = acc & wb.wb_we_i;
    assign rd_acc    = acc & ~wb.wb_we_i;
    assign abort_req = wr_acc && (wb.wb_adr_i == REG_CTRL) && wb.wb_dat_i[CTRL_ABORT];
    assign start_req = wr_acc && (wb.wb_adr_i == REG_CTRL) && wb.wb_dat_i[CTRL_START] && !abort_req;

    assign run_wr   = (state == ST_RUN) && snn_wr_en_i && !abort_req;
    assign grp_last = (grp_cnt == n_out_s - 1'b1);
    assign done_nxt = (&done_cnt) ? done_cnt : done_cnt + 1'b1;
    assign push     = run_wr && (grp_cnt == '0);
    assign pop      = rd_acc && (wb.wb_adr_i == REG_RESULT);
    assign to_nxt   = to_cnt + 1'b1;
    assign to_fire  = (state == ST_RUN) && !snn_wr_en_i && !abort_req &&
                      (timeout_s != '0) && (to_nxt == timeout_s);

    assign snn_start_o = (state == ST_START);

    snn_result_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
        .wb_clk   (wb_clk),
        .wb_rst_n (wb_rst_n),
        .push     (push),
        .push_dat (result_t'({snn_p2_i, snn_p1_i})),
        .pop      (pop),
        .pop_dat  (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_cnt)
    );

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state     <= ST_IDLE;
            grp_cnt   <= '0;
            done_cnt  <= '0;
            to_cnt    <= '0;
            n_out_s   <= CNT_W'(1);
            n_infer_s <= '0;
            timeout_s <= '0;
        end else if (abort_req) begin
            state   <= ST_IDLE;
            grp_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: if (start_req) begin
                    state     <= ST_START;
                    grp_cnt   <= '0;
                    done_cnt  <= '0;
                    to_cnt    <= '0;
                    n_out_s   <= (n_out == '0) ? CNT_W'(1) : n_out;
                    n_infer_s <= n_infer;
                    timeout_s <= timeout;
                end
                ST_START: state <= ST_RUN;
                ST_RUN: begin
                    if (snn_wr_en_i) begin
                        to_cnt <= '0;
                        if (grp_last) begin
                            grp_cnt  <= '0;
                            done_cnt <= done_nxt;
                            if ((n_infer_s != '0) && (done_nxt == n_infer_s))
                                state <= ST_IDLE;
                        end else begin
                            grp_cnt <= grp_cnt + 1'b1;
                        end
                    end else begin
                        to_cnt <= to_nxt;
                        if (to_fire) state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Hardware set of the sticky bits wins over a coincident W1C.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            irq_en  <= 1'b0;
            n_out   <= CNT_W'(1);
            n_infer <= '0;
            timeout <= '0;
            ovf     <= 1'b0;
            to_flag <= 1'b0;
        end else begin
            if (wr_acc) begin
                case (wb.wb_adr_i)
                    REG_CTRL:    irq_en  <= wb.wb_dat_i[CTRL_IRQ_EN];
                    REG_N_OUT:   n_out   <= wb.wb_dat_i[CNT_W-1:0];
                    REG_N_INFER: n_infer <= wb.wb_dat_i[CNT_W-1:0];
                    REG_TIMEOUT: timeout <= wb.wb_dat_i[TO_W-1:0];
                    REG_STATUS: begin
                        if (wb.wb_dat_i[STAT_OVF]) ovf     <= 1'b0;
                        if (wb.wb_dat_i[STAT_TO])  to_flag <= 1'b0;
                    end
                    default: ;
                endcase
            end
            if (push && fifo_full && !pop) ovf <= 1'b1;
            if (to_fire) to_flag <= 1'b1;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (wb.wb_adr_i)
            REG_CTRL:     rd_mux[CTRL_IRQ_EN] = irq_en;
            REG_STATUS: begin
                rd_mux[1:0]                         = state;
                rd_mux[STAT_FIFO_LSB+3:STAT_FIFO_LSB] = 4'(fifo_cnt);
                rd_mux[STAT_OVF]                    = ovf;
                rd_mux[STAT_TO]                     = to_flag;
            end
            REG_N_OUT:    rd_mux[CNT_W-1:0] = n_out;
            REG_N_INFER:  rd_mux[CNT_W-1:0] = n_infer;
            REG_TIMEOUT:  rd_mux[TO_W-1:0]  = timeout;
            REG_RESULT:   rd_mux = fifo_empty ? 32'd0 : fifo_dat;
            REG_DONE_CNT: rd_mux[CNT_W-1:0] = done_cnt;
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            wb.wb_ack_o <= 1'b0;
            wb.wb_dat_o <= '0;
            irq_o       <= 1'b0;
        end else begin
            wb.wb_ack_o <= acc;
            wb.wb_dat_o <= rd_acc ? rd_mux : 32'd0;
            irq_o       <= irq_en & (!fifo_empty | to_flag);
        end
    end
endmodule

// File: tb/tb_snn_infer_ctrl.sv
// Self-checking bench for snn_infer_ctrl: directed scenarios plus randomized group/inference runs.
module tb_snn_infer_ctrl;
    import snn_ctrl_pkg::*;

    logic        wb_clk = 1'b0;
    logic        wb_rst_n = 1'b0;
    logic        snn_start_o, snn_wr_en_i, irq_o;
    logic [15:0] snn_p1_i, snn_p2_i;
    int          total = 0;
    int          bad = 0;

    always #5 wb_clk = ~wb_clk;

    snn_wb_if bus();

    snn_infer_ctrl #(.FIFO_DEPTH(4), .CNT_W(16), .TO_W(24)) dut (
        .wb_clk      (wb_clk),
        .wb_rst_n    (wb_rst_n),
        .wb          (bus),
        .snn_start_o (snn_start_o),
        .snn_wr_en_i (snn_wr_en_i),
        .snn_p1_i    (snn_p1_i),
        .snn_p2_i    (snn_p2_i),
        .irq_o       (irq_o)
    );

    task automatic bus_xfer(input logic we, input logic [2:0] adr, input logic [31:0] wdat,
                            output logic [31:0] rdat);
        bit got = 0;
        rdat = '0;
        bus.wb_adr_i = adr; bus.wb_dat_i = wdat; bus.wb_we_i = we;
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge wb_clk); #1;
            if (bus.wb_ack_o) begin got = 1; rdat = bus.wb_dat_o; end
        end
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
        if (!got) begin
            total++; bad++;
            $display("FAIL bus_ack adr=%0d: no ack within 8 cycles, required ack", adr);
        end
    endtask

    task automatic wb_wr(input logic [2:0] adr, input logic [31:0] d);
        logic [31:0] junk;
        bus_xfer(1'b1, adr, d, junk);
    endtask

    task automatic wb_rd(input logic [2:0] adr, output logic [31:0] d);
        bus_xfer(1'b0, adr, 32'd0, d);
    endtask

    task automatic wr_pulse(input logic [15:0] p1, input logic [15:0] p2);
        snn_p1_i = p1; snn_p2_i = p2; snn_wr_en_i = 1'b1;
        @(posedge wb_clk); #1;
        snn_wr_en_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        total += 4;
        if (bus.wb_ack_o !== 1'b0) begin bad++; $display("FAIL rst_ack got=%b exp=0", bus.wb_ack_o); end
        if (bus.wb_dat_o !== 32'd0) begin bad++; $display("FAIL rst_dat got=%h exp=0", bus.wb_dat_o); end
        if (snn_start_o !== 1'b0) begin bad++; $display("FAIL rst_start got=%b exp=0", snn_start_o); end
        if (irq_o !== 1'b0) begin bad++; $display("FAIL rst_irq got=%b exp=0", irq_o); end
        wb_rst_n = 1'b1;
        @(posedge wb_clk); #1;
        wb_rd(REG_N_OUT, d);  total++;
        if (d !== 32'd1) begin bad++; $display("FAIL rst_n_out got=%h exp=1", d); end
        wb_rd(REG_STATUS, d); total++;
        if (d !== 32'd0) begin bad++; $display("FAIL rst_status got=%h exp=0", d); end
        wb_rd(REG_RESULT, d); total++;
        if (d !== 32'd0) begin bad++; $display("FAIL rst_result got=%h exp=0", d); end
    endtask

    task automatic test_group();
        logic [31:0] d;
        wb_wr(REG_N_OUT, 4); wb_wr(REG_N_INFER, 2); wb_wr(REG_TIMEOUT, 0);
        wb_wr(REG_CTRL, 32'h3);
        total++;
        if (snn_start_o !== 1'b1) begin bad++; $display("FAIL start_pulse got=%b exp=1", snn_start_o); end
        @(posedge wb_clk); #1;
        total++;
        if (snn_start_o !== 1'b0) begin bad++; $display("FAIL start_pulse_end got=%b exp=0", snn_start_o); end
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                wb_rd(REG_STATUS, d); total++;
                if (d[1:0] !== ST_RUN) begin bad++; $display("FAIL grp_running got=%0d exp=2", d[1:0]); end
            end
            wr_pulse(16'(10 + i), 16'hFFFF);
        end
        wb_rd(REG_STATUS, d); total++;
        if (d[1:0] !== ST_IDLE || d[7:4] !== 4'd2) begin
            bad++; $display("FAIL grp_status got=%h exp state=0 count=2", d);
        end
        wb_rd(REG_DONE_CNT, d); total++;
        if (d !== 32'd2) begin bad++; $display("FAIL grp_done got=%0d exp=2", d); end
        total++;
        if (irq_o !== 1'b1) begin bad++; $display("FAIL grp_irq got=%b exp=1", irq_o); end
        wb_rd(REG_RESULT, d); total++;
        if (d !== 32'hFFFF000A) begin bad++; $display("FAIL grp_res0 got=%h exp=ffff000a", d); end
        repeat (2) @(posedge wb_clk); #1;
        total++;
        if (irq_o !== 1'b1) begin bad++; $display("FAIL grp_irq_held got=%b exp=1", irq_o); end
        wb_rd(REG_RESULT, d); total++;
        if (d !== 32'hFFFF000E) begin bad++; $display("FAIL grp_res1 got=%h exp=ffff000e", d); end
        repeat (2) @(posedge wb_clk); #1;
        total++;
        if (irq_o !== 1'b0) begin bad++; $display("FAIL grp_irq_clr got=%b exp=0", irq_o); end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        wb_wr(REG_N_OUT, 1); wb_wr(REG_N_INFER, 0);
        wb_wr(REG_CTRL, 32'h1);
        @(posedge wb_clk); #1;
        for (int i = 1; i <= 5; i++) wr_pulse(16'(i), 16'h0);
        wb_rd(REG_STATUS, d); total++;
        if (d[7:4] !== 4'd4 || d[8] !== 1'b1 || d[1:0] !== ST_RUN) begin
            bad++; $display("FAIL ovf_status got=%h exp count=4 ovf=1 state=2", d);
        end
        wb_wr(REG_CTRL, 32'h1);
        wb_rd(REG_DONE_CNT, d); total++;
        if (d !== 32'd5) begin bad++; $display("FAIL busy_start_ignored done got=%0d exp=5", d); end
        for (int i = 1; i <= 5; i++) begin
            wb_rd(REG_RESULT, d); total++;
            if (d !== ((i <= 4) ? 32'(i) : 32'd0)) begin
                bad++; $display("FAIL ovf_pop%0d got=%h exp=%h", i, d, (i <= 4) ? 32'(i) : 32'd0);
            end
        end
    endtask

    task automatic test_full_pop();
        logic [31:0] d;
        logic [31:0] exp_d [4];
        wb_wr(REG_STATUS, 32'h100);
        for (int i = 0; i < 4; i++) wr_pulse(16'(20 + i), 16'h0);
        @(posedge wb_clk); #1;
        snn_p1_i = 16'd9; snn_p2_i = 16'h0; snn_wr_en_i = 1'b1;
        fork
            wb_rd(REG_RESULT, d);
            begin @(posedge wb_clk); #1; snn_wr_en_i = 1'b0; end
        join
        total++;
        if (d !== 32'd20) begin bad++; $display("FAIL fullpop_res got=%h exp=14", d); end
        wb_rd(REG_STATUS, d); total++;
        if (d[7:4] !== 4'd4 || d[8] !== 1'b0) begin
            bad++; $display("FAIL fullpop_status got=%h exp count=4 ovf=0", d);
        end
        exp_d = '{32'd21, 32'd22, 32'd23, 32'd9};
        for (int i = 0; i < 4; i++) begin
            wb_rd(REG_RESULT, d); total++;
            if (d !== exp_d[i]) begin bad++; $display("FAIL fullpop_drain%0d got=%h exp=%h", i, d, exp_d[i]); end
        end
        wb_wr(REG_CTRL, 32'h4);
        wb_rd(REG_STATUS, d); total++;
        if (d[1:0] !== ST_IDLE) begin bad++; $display("FAIL abort_idle got=%0d exp=0", d[1:0]); end
    endtask

    task automatic test_timeout();
        logic [31:0] d;
        wb_wr(REG_TIMEOUT, 100);
        wb_wr(REG_CTRL, 32'h3);
        repeat (99) @(posedge wb_clk); #1;
        wb_rd(REG_STATUS, d); total++;
        if (d[9] !== 1'b0 || d[1:0] !== ST_RUN) begin
            bad++; $display("FAIL to_early got=%h exp to=0 state=2", d);
        end
        wb_rd(REG_STATUS, d); total++;
        if (d[9] !== 1'b1 || d[1:0] !== ST_IDLE) begin
            bad++; $display("FAIL to_fire got=%h exp to=1 state=0", d);
        end
        total++;
        if (irq_o !== 1'b1) begin bad++; $display("FAIL to_irq got=%b exp=1", irq_o); end
        wb_wr(REG_STATUS, 32'h200);
        repeat (2) @(posedge wb_clk); #1;
        total++;
        if (irq_o !== 1'b0) begin bad++; $display("FAIL to_w1c_irq got=%b exp=0", irq_o); end
        wb_wr(REG_TIMEOUT, 0);
    endtask

    task automatic test_abort();
        logic [31:0] d;
        wb_wr(REG_N_OUT, 3); wb_wr(REG_N_INFER, 0);
        wb_wr(REG_CTRL, 32'h1);
        @(posedge wb_clk); #1;
        wr_pulse(16'd50, 16'd0); wr_pulse(16'd51, 16'd0);
        wb_wr(REG_CTRL, 32'h4);
        wb_wr(REG_CTRL, 32'h1);
        @(posedge wb_clk); #1;
        wr_pulse(16'd7, 16'd0);
        wb_rd(REG_DONE_CNT, d); total++;
        if (d !== 32'd0) begin bad++; $display("FAIL abort_done got=%0d exp=0", d); end
        wb_rd(REG_RESULT, d); total++;
        if (d !== 32'd50) begin bad++; $display("FAIL abort_res0 got=%h exp=32", d); end
        wb_rd(REG_RESULT, d); total++;
        if (d !== 32'd7) begin bad++; $display("FAIL abort_res1 got=%h exp=7", d); end
        wb_wr(REG_CTRL, 32'h5);
        total++;
        if (snn_start_o !== 1'b0) begin bad++; $display("FAIL start_abort_pulse got=%b exp=0", snn_start_o); end
        wb_rd(REG_STATUS, d); total++;
        if (d[1:0] !== ST_IDLE) begin bad++; $display("FAIL start_abort_state got=%0d exp=0", d[1:0]); end
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic [31:0] exp_q [$];
        for (int it = 0; it < 6; it++) begin
            int n_out = $urandom_range(1, 4);
            int n_inf = $urandom_range(1, 6);
            int nw = $urandom_range(1, n_out * n_inf + 2);
            int limit = n_out * n_inf;
            int processed = (nw < limit) ? nw : limit;
            bit ovf = 0;
            exp_q.delete();
            wb_wr(REG_STATUS, 32'h300);
            wb_wr(REG_N_OUT, 32'(n_out)); wb_wr(REG_N_INFER, 32'(n_inf));
            wb_wr(REG_CTRL, 32'h1);
            @(posedge wb_clk); #1;
            for (int i = 0; i < nw; i++) begin
                logic [15:0] p1 = 16'($urandom);
                logic [15:0] p2 = 16'($urandom);
                repeat ($urandom_range(0, 2)) begin @(posedge wb_clk); #1; end
                if (i < processed && i % n_out == 0) begin
                    if (exp_q.size() < 4) exp_q.push_back({p2, p1});
                    else ovf = 1;
                end
                wr_pulse(p1, p2);
            end
            wb_rd(REG_STATUS, d); total++;
            if (d[1:0] !== ((processed == limit) ? ST_IDLE : ST_RUN) ||
                d[7:4] !== 4'(exp_q.size()) || d[8] !== ovf) begin
                bad++;
                $display("FAIL rnd%0d_status got=%h exp state=%0d count=%0d ovf=%0d", it, d,
                         (processed == limit) ? 0 : 2, exp_q.size(), ovf);
            end
            wb_rd(REG_DONE_CNT, d); total++;
            if (d !== 32'(processed / n_out)) begin
                bad++; $display("FAIL rnd%0d_done got=%0d exp=%0d", it, d, processed / n_out);
            end
            wb_wr(REG_CTRL, 32'h4);
            while (exp_q.size() > 0) begin
                logic [31:0] e = exp_q.pop_front();
                wb_rd(REG_RESULT, d); total++;
                if (d !== e) begin bad++; $display("FAIL rnd%0d_pop got=%h exp=%h", it, d, e); end
            end
            wb_rd(REG_RESULT, d); total++;
            if (d !== 32'd0) begin bad++; $display("FAIL rnd%0d_empty got=%h exp=0", it, d); end
        end
    endtask

    initial begin
        bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.wb_we_i = 1'b0;
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
        snn_wr_en_i = 1'b0; snn_p1_i = '0; snn_p2_i = '0;
        repeat (3) @(posedge wb_clk); #1;
        test_reset();
        test_group();
        test_overflow();
        test_full_pop();
        test_timeout();
        test_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end
endmodule
